challenge_auth: RTL and testbench

Consumes the 16-bit pseudo-random word from the LFSR and runs one challenge-response authentication exchange per request.
- On start: steps the LFSR a fixed number of cycles, latches a challenge, and offers it to the UART TX path over a valid/ready handshake.
- Then waits, with a timeout, for the 16-bit response from the UART RX path and reports pass or fail.
- Drives the LFSR's enable; sits between the LFSR and the UART framing logic.

---
 rtl/challenge_auth_pkg.sv | 22 ++
 rtl/challenge_auth_timer.sv | 36 +++
 rtl/challenge_auth.sv | 168 ++++++++++++++++
 tb/tb_challenge_auth.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/challenge_auth_pkg.sv
// Shared types and helpers for the challenge-response authenticator.
// The response rule lives here so every user computes it the same way.
package challenge_auth_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MIX       = 3'd1,
      CAPTURE   = 3'd2,
      ISSUE     = 3'd3,
      WAIT_RESP = 3'd4,
      LOCKOUT   = 3'd5
   } state_e;

   localparam int ROT = 3;

   // Rotate the challenge left by ROT, then mix in the shared key.
   function automatic logic [15:0] calc_response(input logic [15:0] chal,
                                                 input logic [15:0] key);
      return {chal[15-ROT:0], chal[15:16-ROT]} ^ key;
   endfunction

endpackage

// File: rtl/challenge_auth_timer.sv
// Cycle timer: clears to zero, counts while enabled, flags the TIMEOUT-1 count.
// The module is named auth_timer and is shared by the response and lockout windows.
module auth_timer #(
   parameter int unsigned TIMEOUT = 12_000_000,
   parameter int          TIMER_W = 24
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (enable)
         count_d = count_q + TIMER_W'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign terminal = (count_q == LAST);

endmodule

// File: rtl/challenge_auth.sv
// One challenge-response exchange per start: mix the LFSR, issue a challenge, judge the reply.
// Define CHALLENGE_AUTH_LOCKOUT_EN to add a three-strike lockout of 4*TIMEOUT cycles.
module challenge_auth
   import challenge_auth_pkg::*;
#(
   parameter logic [15:0] KEY        = 16'h5A3C,
   parameter int unsigned MIX_CYCLES = 8,
   parameter int unsigned TIMEOUT    = 12_000_000,
   parameter int          TIMER_W    = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        lfsr_en,
   input  logic [15:0] lfsr_random,
   output logic [15:0] challenge,
   output logic        challenge_valid,
   input  logic        challenge_ready,
   input  logic [15:0] resp_data,
   input  logic        resp_valid,
   output logic        busy,
   output logic        auth_ok,
   output logic        auth_fail,
   output logic        unlocked
);

   localparam logic [7:0] MIX_LAST = 8'(MIX_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  mix_cnt_q, mix_cnt_d;
   logic [15:0] challenge_q, challenge_d;
   logic [15:0] expected_q, expected_d;
   logic        unlocked_q, unlocked_d;
   logic        auth_ok_q, auth_ok_d;
   logic        auth_fail_q, auth_fail_d;
   logic        resp_timeout;

   // Timer sits at zero outside WAIT_RESP, so the window opens on the handshake edge.
   auth_timer #(
      .TIMEOUT (TIMEOUT),
      .TIMER_W (TIMER_W)
   ) u_resp_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state_q != WAIT_RESP),
      .enable   (state_q == WAIT_RESP),
      .terminal (resp_timeout)
   );

`ifdef CHALLENGE_AUTH_LOCKOUT_EN
   logic [1:0] fail_cnt_q, fail_cnt_d;
   logic       lock_done;

   auth_timer #(
      .TIMEOUT (4 * TIMEOUT),
      .TIMER_W (TIMER_W + 2)
   ) u_lock_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state_q != LOCKOUT),
      .enable   (state_q == LOCKOUT),
      .terminal (lock_done)
   );
`endif

   // NOTE: every variable gets a default first, so no branch can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      mix_cnt_d   = mix_cnt_q;
      challenge_d = challenge_q;
      expected_d  = expected_q;
      unlocked_d  = unlocked_q;
      auth_ok_d   = 1'b0;
      auth_fail_d = 1'b0;
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
      fail_cnt_d  = fail_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = MIX;
               mix_cnt_d  = '0;
               unlocked_d = 1'b0;
            end
         end
         MIX: begin
            if (mix_cnt_q == MIX_LAST)
               state_d = CAPTURE;
            else
               mix_cnt_d = mix_cnt_q + 8'd1;
         end
         CAPTURE: begin
            challenge_d = lfsr_random;
            expected_d  = calc_response(lfsr_random, KEY);
            state_d     = ISSUE;
         end
         ISSUE: begin
            if (challenge_ready)
               state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            // A response arriving on the terminal cycle takes priority over the timeout.
            if (resp_valid && (resp_data == expected_q)) begin
               auth_ok_d  = 1'b1;
               unlocked_d = 1'b1;
               state_d    = IDLE;
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
               fail_cnt_d = '0;
`endif
            end else if (resp_valid || resp_timeout) begin
               auth_fail_d = 1'b1;
               unlocked_d  = 1'b0;
               state_d     = IDLE;
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
               if (fail_cnt_q != 2'd3)
                  fail_cnt_d = fail_cnt_q + 2'd1;
               if (fail_cnt_q >= 2'd2)
                  state_d = LOCKOUT;
`endif
            end
         end
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
         LOCKOUT: begin
            if (lock_done) begin
               state_d    = IDLE;
               fail_cnt_d = '0;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mix_cnt_q   <= '0;
         challenge_q <= '0;
         expected_q  <= '0;
         unlocked_q  <= 1'b0;
         auth_ok_q   <= 1'b0;
         auth_fail_q <= 1'b0;
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
         fail_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mix_cnt_q   <= mix_cnt_d;
         challenge_q <= challenge_d;
         expected_q  <= expected_d;
         unlocked_q  <= unlocked_d;
         auth_ok_q   <= auth_ok_d;
         auth_fail_q <= auth_fail_d;
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
         fail_cnt_q  <= fail_cnt_d;
`endif
      end
   end

   assign lfsr_en         = (state_q == MIX);
   assign challenge_valid = (state_q == ISSUE);
   assign busy            = (state_q != IDLE);
   assign challenge       = challenge_q;
   assign auth_ok         = auth_ok_q;
   assign auth_fail       = auth_fail_q;
   assign unlocked        = unlocked_q;

endmodule

// File: tb/tb_challenge_auth.sv
// Directed bench for challenge_auth with TIMEOUT shortened to 100 cycles.
// Lockout scenario runs only when CHALLENGE_AUTH_LOCKOUT_EN is defined.
module tb_challenge_auth;
   import challenge_auth_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        lfsr_en;
   logic [15:0] lfsr_random;
   logic [15:0] challenge;
   logic        challenge_valid;
   logic        challenge_ready;
   logic [15:0] resp_data;
   logic        resp_valid;
   logic        busy;
   logic        auth_ok;
   logic        auth_fail;
   logic        unlocked;

   int n_checks = 0;
   int n_errors = 0;

   challenge_auth #(
      .KEY        (16'h5A3C),
      .MIX_CYCLES (8),
      .TIMEOUT    (100),
      .TIMER_W    (24)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .lfsr_en         (lfsr_en),
      .lfsr_random     (lfsr_random),
      .challenge       (challenge),
      .challenge_valid (challenge_valid),
      .challenge_ready (challenge_ready),
      .resp_data       (resp_data),
      .resp_valid      (resp_valid),
      .busy            (busy),
      .auth_ok         (auth_ok),
      .auth_fail       (auth_fail),
      .unlocked        (unlocked)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start an exchange and carry it through the challenge handshake.
   task automatic issue(input logic [15:0] rnd, input int stall, input bit hold_start);
      int n;
      int bad;
      lfsr_random     = rnd;
      challenge_ready = (stall == 0);
      start           = 1'b1;
      step();
      start = hold_start;
      check("unlocked_clr_on_start", unlocked, 0);
      n = 0;
      while (lfsr_en && n < 40) begin
         n++;
         step();
      end
      start = 1'b0;
      check("mix_len", n, 8);
      check("capture_busy", busy, 1);
      step();
      check("issue_valid", challenge_valid, 1);
      check("issue_chal", challenge, rnd);
      if (stall > 0) begin
         lfsr_random = ~rnd;
         bad = 0;
         for (int i = 0; i < stall; i++) begin
            step();
            if (challenge_valid !== 1'b1 || challenge !== rnd) bad++;
         end
         check("backpressure_stable", bad, 0);
         challenge_ready = 1'b1;
      end
      step();
      challenge_ready = 1'b0;
      check("valid_drop", challenge_valid, 0);
      check("wait_busy", busy, 1);
   endtask

   // Present one response; check the pulse cycle and the cycle after it.
   task automatic respond(input logic [15:0] data, input bit ok, input bit exp_busy);
      resp_data  = data;
      resp_valid = 1'b1;
      step();
      resp_valid = 1'b0;
      check("auth_ok", auth_ok, ok);
      check("auth_fail", auth_fail, !ok);
      check("pulse_busy", busy, exp_busy);
      check("unlocked", unlocked, ok);
      step();
      check("pulse_width", auth_ok | auth_fail, 0);
      check("after_busy", busy, exp_busy);
   endtask

   initial begin
      int n;
      int seen;
      rst_n           = 1'b0;
      start           = 1'b0;
      lfsr_random     = 16'h0;
      challenge_ready = 1'b0;
      resp_data       = 16'h0;
      resp_valid      = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // reset state
      check("rst_busy", busy, 0);
      check("rst_chal", challenge, 0);
      check("rst_outs", {lfsr_en, challenge_valid, auth_ok, auth_fail, unlocked}, 0);
      check("func_ref", calc_response(16'h1234, 16'h5A3C), 16'hCB9C);

      // passing exchange
      issue(16'h1234, 0, 1'b0);
      respond(16'hCB9C, 1'b1, 1'b0);

      // wrong response
      issue(16'h1234, 0, 1'b0);
      respond(16'hCB9D, 1'b0, 1'b0);

      // backpressure then timeout
      issue(16'hA5F0, 20, 1'b0);
      n    = 0;
      seen = 0;
      while (!auth_fail && n < 300) begin
         step();
         n++;
         if (auth_ok) seen++;
      end
      check("timeout_cycles", n, 100);
      check("timeout_no_ok", seen, 0);
      check("timeout_busy", busy, 0);
      check("timeout_unlocked", unlocked, 0);
      step();
      check("timeout_pulse_width", auth_fail, 0);

      // response exactly on the terminal cycle
      issue(16'hA5F0, 0, 1'b0);
      seen = 0;
      repeat (99) begin
         step();
         if (auth_ok || auth_fail) seen++;
      end
      check("terminal_no_early_pulse", seen, 0);
      check("terminal_still_busy", busy, 1);
      respond(16'h75B9, 1'b1, 1'b0);

      // start held through MIX, then resp_valid while IDLE
      issue(16'h8001, 0, 1'b1);
      respond(16'h5A30, 1'b1, 1'b0);
      resp_data  = 16'h5A30;
      resp_valid = 1'b1;
      seen       = 0;
      repeat (3) begin
         step();
         if (auth_ok || auth_fail || busy) seen++;
      end
      resp_valid = 1'b0;
      check("idle_resp_ignored", seen, 0);
      check("idle_unlocked_kept", unlocked, 1);

      // asynchronous reset mid WAIT_RESP
      issue(16'h1234, 0, 1'b0);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_chal", challenge, 0);
      check("arst_outs", {lfsr_en, challenge_valid, auth_ok, auth_fail, unlocked}, 0);
      step();
      rst_n = 1'b1;
      seen  = 0;
      repeat (5) begin
         step();
         if (auth_ok || auth_fail || busy) seen++;
      end
      check("arst_no_pulse", seen, 0);

`ifdef CHALLENGE_AUTH_LOCKOUT_EN
      // three strikes -> lockout
      for (int k = 0; k < 3; k++) begin
         issue(16'h1234, 0, 1'b0);
         respond(16'hCB9D, 1'b0, k == 2);
      end
      n    = 1;
      seen = 0;
      start = 1'b1;
      while (busy && n < 1000) begin
         if (lfsr_en || challenge_valid) seen++;
         if (n >= 50) start = 1'b0;
         n++;
         step();
      end
      start = 1'b0;
      check("lockout_cycles", n, 400);
      check("lockout_start_ignored", seen, 0);
      issue(16'h8001, 0, 1'b0);
      respond(16'h5A30, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
